fitness_scheduler: RTL and testbench

//  Sequences one population through the dual-lane fitness unit (two 8-bit signed chroms in, two 27-bit signed fitness out).
//  - Reads chromosome pairs from population RAM and issues one pair per cycle.
//  - Tracks fitness pipeline latency with a valid/tag shift register.
//  - Writes results back to fitness RAM; pulses done when the whole population is scored.
//  - Sits between the GA top-level FSM and the fitness_function datapath.

---
 rtl/fitness_scheduler.sv | 174 +++++++++++++++++
 tb/tb_fitness_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fitness_scheduler.sv
// fitness_scheduler
//   Sequences one population through the dual-lane fitness unit. Chromosome
//   pairs are read from population RAM (one pair per cycle), registered onto
//   the fitness lanes, tracked through the unit's latency by a valid/tag shift
//   register, and written back to fitness RAM in pair order. done pulses for
//   one cycle once every pair has been written.
//
//   Optional feature macro: BEST_TRACK_EN
//     defined   : best_fitness/best_index track the best result of the run
//     undefined : best_fitness/best_index are tied to 0
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   start                    begin scoring (sampled only in IDLE)
//   busy, done               busy in RUN/DRAIN, done 1-cycle pulse
//   pop_rd_en/addr/data1/2   population RAM read port (1-cycle read latency)
//   chrom1, chrom2           registered chromosomes to the fitness lanes
//   ff_enable                fitness unit advance enable
//   fitness1, fitness2       fitness lane results
//   res_wr_en/addr/data1/2   fitness RAM write port
//   best_fitness, best_index best result of the last run and its chromosome index
module fitness_scheduler #(
    parameter int POP_SIZE   = 16,
    parameter int CHROM_W    = 8,
    parameter int FIT_W      = 27,
    parameter int FF_LATENCY = 3,
    localparam int P  = POP_SIZE / 2,
    localparam int AW = (P > 1) ? $clog2(P) : 1,
    localparam int IW = $clog2(POP_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      pop_rd_en,
    output logic [AW-1:0]             pop_rd_addr,
    input  logic signed [CHROM_W-1:0] pop_rd_data1,
    input  logic signed [CHROM_W-1:0] pop_rd_data2,
    output logic signed [CHROM_W-1:0] chrom1,
    output logic signed [CHROM_W-1:0] chrom2,
    output logic                      ff_enable,
    input  logic signed [FIT_W-1:0]   fitness1,
    input  logic signed [FIT_W-1:0]   fitness2,
    output logic                      res_wr_en,
    output logic [AW-1:0]             res_wr_addr,
    output logic signed [FIT_W-1:0]   res_wr_data1,
    output logic signed [FIT_W-1:0]   res_wr_data2,
    output logic signed [FIT_W-1:0]   best_fitness,
    output logic [IW-1:0]             best_index
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW-1:0] LAST_K = AW'(P - 1);

    logic [1:0]                state_q;
    logic [AW-1:0]             k_q;
    logic                      rd_v_q;
    logic [AW-1:0]             rd_k_q;
    logic signed [CHROM_W-1:0] chrom1_q, chrom2_q;
    // Stage 0 lines up with the chrom registers; stage FF_LATENCY with the result.
    logic [FF_LATENCY:0]       vld_q;
    logic [AW-1:0]             tag_q [FF_LATENCY+1];

    logic last_write;

    always_comb begin
        busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
        done         = (state_q == S_DONE);
        pop_rd_en    = (state_q == S_RUN);
        pop_rd_addr  = pop_rd_en ? k_q : '0;
        chrom1       = chrom1_q;
        chrom2       = chrom2_q;
        ff_enable    = |vld_q;
        res_wr_en    = vld_q[FF_LATENCY];
        res_wr_addr  = res_wr_en ? tag_q[FF_LATENCY] : '0;
        res_wr_data1 = res_wr_en ? fitness1 : '0;
        res_wr_data2 = res_wr_en ? fitness2 : '0;
        last_write   = res_wr_en && (tag_q[FF_LATENCY] == LAST_K);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            rd_v_q   <= 1'b0;
            rd_k_q   <= '0;
            chrom1_q <= '0;
            chrom2_q <= '0;
            vld_q    <= '0;
            for (int i = 0; i <= FF_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        k_q     <= '0;
                    end
                end
                S_RUN: begin
                    // Issue counter saturates at the last pair.
                    if (k_q == LAST_K) begin
                        state_q <= S_DRAIN;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (last_write) begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            rd_v_q <= pop_rd_en;
            rd_k_q <= k_q;

            // Empty slots present zeros so the unit sees defined data.
            chrom1_q <= rd_v_q ? pop_rd_data1 : '0;
            chrom2_q <= rd_v_q ? pop_rd_data2 : '0;
            vld_q[0] <= rd_v_q;
            tag_q[0] <= rd_v_q ? rd_k_q : '0;
            for (int i = 1; i <= FF_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

`ifdef BEST_TRACK_EN
    localparam logic signed [FIT_W-1:0] FIT_MIN = {1'b1, {(FIT_W-1){1'b0}}};

    logic signed [FIT_W-1:0] best_q;
    logic [IW-1:0]           best_idx_q;
    logic signed [FIT_W-1:0] win_fit;
    logic                    win_lane;

    // Lane 2 wins only when strictly greater, so lane 1 (index 2k) takes ties.
    always_comb begin
        win_lane = (fitness2 > fitness1);
        win_fit  = win_lane ? fitness2 : fitness1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_q     <= FIT_MIN;
            best_idx_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            best_q     <= FIT_MIN;
            best_idx_q <= '0;
        end else if (res_wr_en && (win_fit > best_q)) begin
            // Strict compare keeps the earlier pair on cross-pair ties.
            best_q     <= win_fit;
            best_idx_q <= IW'({tag_q[FF_LATENCY], win_lane});
        end
    end

    assign best_fitness = best_q;
    assign best_index   = best_idx_q;
`else
    assign best_fitness = '0;
    assign best_index   = '0;
`endif

endmodule

// File: tb/tb_fitness_scheduler.sv
module tb_fitness_scheduler;

    localparam int POP = 16;
    localparam int CW  = 8;
    localparam int FW  = 27;
    localparam int LAT = 3;
    localparam int P   = POP / 2;
    localparam int AW  = 3;
    localparam int IW  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 busy, done, pop_rd_en, ff_enable, res_wr_en;
    logic [AW-1:0]        pop_rd_addr, res_wr_addr;
    logic signed [CW-1:0] pop_rd_data1, pop_rd_data2, chrom1, chrom2;
    logic signed [FW-1:0] fitness1, fitness2, res_wr_data1, res_wr_data2, best_fitness;
    logic [IW-1:0]        best_index;

    int checks = 0;
    int errors = 0;

    fitness_scheduler #(
        .POP_SIZE(POP), .CHROM_W(CW), .FIT_W(FW), .FF_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pop_rd_en(pop_rd_en), .pop_rd_addr(pop_rd_addr),
        .pop_rd_data1(pop_rd_data1), .pop_rd_data2(pop_rd_data2),
        .chrom1(chrom1), .chrom2(chrom2), .ff_enable(ff_enable),
        .fitness1(fitness1), .fitness2(fitness2),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
        .res_wr_data1(res_wr_data1), .res_wr_data2(res_wr_data2),
        .best_fitness(best_fitness), .best_index(best_index)
    );

    always #5 clk = ~clk;

    // Population RAM with one-cycle read latency.
    logic signed [CW-1:0] mem [POP];
    always @(posedge clk) begin
        if (pop_rd_en) begin
            pop_rd_data1 <= mem[2 * int'(pop_rd_addr)];
            pop_rd_data2 <= mem[2 * int'(pop_rd_addr) + 1];
        end
    end

    // Fitness stub: fitness = sign-extended chrom, LAT enabled cycles later.
    logic signed [FW-1:0] fp1 [LAT];
    logic signed [FW-1:0] fp2 [LAT];
    initial begin
        for (int i = 0; i < LAT; i++) begin
            fp1[i] = '0;
            fp2[i] = '0;
        end
        pop_rd_data1 = '0;
        pop_rd_data2 = '0;
    end
    always @(posedge clk) begin
        if (ff_enable) begin
            fp1[0] <= FW'(chrom1);
            fp2[0] <= FW'(chrom2);
            for (int i = 1; i < LAT; i++) begin
                fp1[i] <= fp1[i-1];
                fp2[i] <= fp2[i-1];
            end
        end
    end
    assign fitness1 = fp1[LAT-1];
    assign fitness2 = fp2[LAT-1];

    // Cycle counter and observation queues, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_addr_q[$], wr_d1_q[$], wr_d2_q[$], wr_cyc_q[$], rd_addr_q[$], done_cyc_q[$];
    int busy_cnt;
    int best_at_done;
    int idx_at_done;

    always @(negedge clk) begin
        if (res_wr_en) begin
            wr_addr_q.push_back(int'(res_wr_addr));
            wr_d1_q.push_back(int'(res_wr_data1));
            wr_d2_q.push_back(int'(res_wr_data2));
            wr_cyc_q.push_back(cyc);
        end
        if (pop_rd_en) rd_addr_q.push_back(int'(pop_rd_addr));
        if (busy) busy_cnt++;
        if (done) begin
            done_cyc_q.push_back(cyc);
            best_at_done = int'(best_fitness);
            idx_at_done  = int'(best_index);
        end
    end

    task automatic clear_obs();
        wr_addr_q.delete();
        wr_d1_q.delete();
        wr_d2_q.delete();
        wr_cyc_q.delete();
        rd_addr_q.delete();
        done_cyc_q.delete();
        busy_cnt = 0;
    endtask

    task automatic test_reset();
        int exp_best;
`ifdef BEST_TRACK_EN
        exp_best = -(1 << (FW - 1));
`else
        exp_best = 0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, pop_rd_en, ff_enable, res_wr_en} !== 5'b0 ||
            pop_rd_addr !== '0 || res_wr_addr !== '0 || chrom1 !== '0 || chrom2 !== '0 ||
            res_wr_data1 !== '0 || res_wr_data2 !== '0 || best_index !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd=%b ffe=%b wr=%b c1=%0d c2=%0d, want all 0",
                     busy, done, pop_rd_en, ff_enable, res_wr_en, chrom1, chrom2);
        end
        checks++;
        if (int'(best_fitness) != exp_best) begin
            errors++;
            $display("FAIL reset_best: got %0d want %0d", best_fitness, exp_best);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs the loaded population once and checks it against a plain model.
    task automatic test_run(input string name, input bit extra_start);
        int ef[POP];
        int eb, ei, s, n, nw;
        for (int i = 0; i < POP; i++) ef[i] = int'(mem[i]);
        eb = ef[0];
        ei = 0;
        for (int i = 1; i < POP; i++) begin
            if (ef[i] > eb) begin
                eb = ef[i];
                ei = i;
            end
        end
`ifndef BEST_TRACK_EN
        eb = 0;
        ei = 0;
`endif
        clear_obs();
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        if (extra_start) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (done_cyc_q.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);

        checks++;
        if (done_cyc_q.size() != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d want 1", name, done_cyc_q.size());
        end else begin
            checks++;
            if (done_cyc_q[0] - s != P + 3 + LAT) begin
                errors++;
                $display("FAIL %s done_latency: got %0d want %0d", name, done_cyc_q[0] - s,
                         P + 3 + LAT);
            end
            checks++;
            if (best_at_done != eb || idx_at_done != ei) begin
                errors++;
                $display("FAIL %s best: got %0d@%0d want %0d@%0d", name, best_at_done,
                         idx_at_done, eb, ei);
            end
        end
        checks++;
        if (wr_addr_q.size() != P) begin
            errors++;
            $display("FAIL %s write_count: got %0d want %0d", name, wr_addr_q.size(), P);
        end
        nw = (wr_addr_q.size() < P) ? wr_addr_q.size() : P;
        for (int k = 0; k < nw; k++) begin
            checks++;
            if (wr_addr_q[k] != k || wr_d1_q[k] != ef[2*k] || wr_d2_q[k] != ef[2*k+1] ||
                wr_cyc_q[k] - s != 3 + LAT + k) begin
                errors++;
                $display("FAIL %s write%0d: got addr=%0d d=(%0d,%0d) t=%0d want addr=%0d d=(%0d,%0d) t=%0d",
                         name, k, wr_addr_q[k], wr_d1_q[k], wr_d2_q[k], wr_cyc_q[k] - s,
                         k, ef[2*k], ef[2*k+1], 3 + LAT + k);
            end
        end
        checks++;
        if (rd_addr_q.size() != P) begin
            errors++;
            $display("FAIL %s read_count: got %0d want %0d", name, rd_addr_q.size(), P);
        end else begin
            for (int k = 0; k < P; k++) begin
                checks++;
                if (rd_addr_q[k] != k) begin
                    errors++;
                    $display("FAIL %s read%0d: got addr %0d want %0d", name, k, rd_addr_q[k], k);
                end
            end
        end
        checks++;
        if (busy_cnt != P + 2 + LAT) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, P + 2 + LAT);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < POP; i++) mem[i] = CW'(i - 8);
        test_run("ramp", 1'b0);
    endtask

    task automatic test_busy_start();
        for (int i = 0; i < POP; i++) mem[i] = CW'(i - 8);
        test_run("busy_start", 1'b1);
    endtask

    task automatic test_ties();
        for (int i = 0; i < POP; i++) mem[i] = CW'(5);
        test_run("all_five", 1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < POP; i++) mem[i] = CW'(int'($urandom_range(0, 3)) - 2);
            test_run("small_ties", 1'b0);
        end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < POP; i++) mem[i] = CW'(-1);
        mem[6] = CW'(-128);
        mem[7] = CW'(127);
        test_run("extremes", 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < POP; i++) mem[i] = CW'($urandom_range(0, 255));
            test_run("random", 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        for (int i = 0; i < POP; i++) mem[i] = CW'(i - 8);
        clear_obs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(res_wr_en && res_wr_addr == AW'(2)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL mid_reset_third_write: got no third write, want one");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, pop_rd_en, ff_enable, res_wr_en} !== 5'b0 ||
            chrom1 !== '0 || chrom2 !== '0 || res_wr_data1 !== '0 || res_wr_data2 !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b rd=%b ffe=%b wr=%b, want all 0",
                     busy, done, pop_rd_en, ff_enable, res_wr_en);
        end
        rst = 1'b0;
        clear_obs();
        repeat (20) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 0 || done_cyc_q.size() != 0 || busy_cnt != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got writes=%0d dones=%0d busy=%0d want 0 0 0",
                     wr_addr_q.size(), done_cyc_q.size(), busy_cnt);
        end
        test_run("after_reset", 1'b0);
    endtask

    initial begin
        for (int i = 0; i < POP; i++) mem[i] = '0;
        clear_obs();
        @(negedge clk);
        test_reset();
        test_ramp();
        test_busy_start();
        test_ties();
        test_extremes();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
